// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential signed divider.
// The requester drives start and operands; the divider returns status and results.
interface seq_divider_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift/subtract signed divider, one quotient bit per cycle.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | one restoring iteration per cycle, DIVIDEND_W cycles
// FIX   | apply signs and special cases, register results, pulse done
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam int REM_W = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic                  neg_dvd_q, neg_dvd_d;
    logic                  neg_dsr_q, neg_dsr_d;
    logic                  ovf_pend_q, ovf_pend_d;

    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  remo_q, remo_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // One extra bit above the partial remainder exposes the trial-subtract borrow.
    logic [REM_W:0]        shifted;
    logic [REM_W:0]        trial;

    always_comb begin
        shifted = {rem_q, dvd_q[DIVIDEND_W-1]};
        trial   = shifted - {2'b00, dsr_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            neg_dvd_q  <= 1'b0;
            neg_dsr_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            remo_q     <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            neg_dvd_q  <= neg_dvd_d;
            neg_dsr_q  <= neg_dsr_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            remo_q     <= remo_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        neg_dvd_d  = neg_dvd_q;
        neg_dsr_d  = neg_dsr_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        remo_d     = remo_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_dvd_d  = bus.dividend[DIVIDEND_W-1];
                    neg_dsr_d  = bus.divisor[DIVISOR_W-1];
                    dvd_d      = bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
                    dsr_d      = bus.divisor[DIVISOR_W-1] ? -bus.divisor : bus.divisor;
                    ovf_pend_d = (bus.dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) &&
                                 (bus.divisor == {DIVISOR_W{1'b1}});
                    rem_d      = '0;
                    cnt_d      = CNT_W'(DIVIDEND_W - 1);
                    busy_d     = 1'b1;
                    state_d    = CALC;
                end
            end

            CALC: begin
                if (trial[REM_W]) begin
                    rem_d = shifted[REM_W-1:0];
                    dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                end else begin
                    rem_d = trial[REM_W-1:0];
                    dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b1};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                quot_d = (neg_dvd_q ^ neg_dsr_q) ? -dvd_q : dvd_q;
                remo_d = neg_dvd_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
                dbz_d  = 1'b0;
                ovf_d  = ovf_pend_q;
                // A zero divisor ran the full loop only to keep latency constant.
                if (dsr_q == '0) begin
                    quot_d = '1;
                    remo_d = '0;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential signed integer divider, the inverse of the team's combinational 4x4 signed multiplier. It takes a signed DIVIDEND_W-bit dividend and a signed DIVISOR_W-bit divisor, and produces a truncated quotient and remainder. It uses a restoring shift/subtract loop at one quotient bit per cycle, behind a start/done handshake. It sits beside the multiplier in the arithmetic experiments and serves as the multi-cycle DIV unit for the ALU.

## Interface
- DIVIDEND_W, 8, dividend and quotient width, two's complement
- DIVISOR_W, 4, divisor and remainder width, two's complement
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  DIVIDEND_W  signed; captured on accepted start
- divisor  input  DIVISOR_W  signed; captured on accepted start
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse when results are valid
- quotient  output  DIVIDEND_W  signed, held until the next done
- remainder  output  DIVISOR_W  signed, held until the next done
- div_by_zero  output  1  error flag for the operation just completed, held with the results
- overflow  output  1  quotient not representable, held with the results

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - When start=1, capture the signs of both operands and the magnitudes |dividend| (DIVIDEND_W bits, unsigned) and |divisor| (DIVISOR_W bits, unsigned).
  - Clear the partial remainder (DIVISOR_W+1 bits) and load the bit counter with DIVIDEND_W-1.
  - Go to CALC.
- CALC, each cycle:
  - Shift {partial remainder, dividend magnitude} left 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. After DIVIDEND_W iterations, go to FIX.
- FIX:
  - Negate the quotient magnitude if the signs differ. Negate the remainder magnitude if the dividend is negative, so truncation is toward zero and the remainder takes the dividend's sign.
  - Register all outputs, pulse done, return to IDLE.
- Divisor = 0: run the full loop for constant latency. In FIX, force quotient = all ones, remainder = 0, div_by_zero = 1, overflow = 0.
- Dividend = most-negative value and divisor = -1: quotient = most-negative value (wraps), remainder = 0, overflow = 1.
- Otherwise both flags are 0.
- |remainder| < |divisor| ≤ 2^(DIVISOR_W-1), so the remainder always fits DIVISOR_W signed bits.
- A start while busy is ignored with no queuing. Input changes after accept have no effect.
- Reset values: state IDLE; busy, done, flags = 0; quotient = 0; remainder = 0; all internal registers = 0.
- Reset asserted mid-operation aborts immediately. No done is produced for the aborted operation.

## Timing
- Start is accepted at clock edge E0 with state IDLE and start=1.
- busy = 1 from E0 through E(DIVIDEND_W+1). CALC occupies E1..E(DIVIDEND_W).
- At E(DIVIDEND_W+1), FIX registers the results, done rises for exactly one cycle, and busy falls.
- Latency is DIVIDEND_W+1 cycles (9 for the defaults), independent of operand values.
- A new start may be asserted in the same cycle that done is high: state is already IDLE, so it is accepted at the next edge. Throughput is one operation per DIVIDEND_W+2 cycles.
- Outputs change only at the FIX edge or on reset.

## Test plan
- 100 / 7 -> quotient 8'h0E (14), remainder 4'h2, flags 0; done exactly 9 cycles after the accepting edge.
- -100 / 7 -> quotient 8'hF2 (-14), remainder 4'hE (-2). 100 / -7 -> quotient 8'hF2, remainder 4'h2. -100 / -8 -> quotient 8'h0C (12), remainder 4'hC (-4).
- 5 / 0 -> div_by_zero=1, quotient 8'hFF, remainder 0, latency still 9. -128 / -1 -> quotient 8'h80, remainder 0, overflow=1.
- start held high continuously with changing operands -> only the first is accepted while busy; the next acceptance happens in the done cycle; results match the captured operands.
- rst_n pulsed low at cycle 4 of an operation -> all outputs return to 0 immediately; no done pulse. A fresh 100 / 7 afterwards completes correctly.
- Exhaustive sweep of all 256x16 operand pairs against a reference model (truncating division, divisor=0 and overflow rules above) -> zero mismatches.
